// File: rtl/npc_sequencer.sv
// npc_sequencer: F-stage PC controller for a 5-stage MIPS pipeline.
// Owns the fetch PC and picks the next PC from JR, J/JAL, a taken branch,
// or the sequential PC+4. It holds on hazard stalls, counts PC advances,
// and halts permanently (until reset) when the next fetch address is illegal.
//
// Handshake: there is no valid/ready pairing here. A redirect (jr_valid,
// j_valid, br_valid&br_taken) is sampled on every rising edge with
// stall=0 while in RUN. With stall=1 the redirect is ignored and the
// D stage re-presents it once the stall drops. In HALT every input except
// reset is ignored.
//
// The FSM state is visible on the halted output (halted=1 means HALT).
module npc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BYTES = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        j_valid,
  input  logic [31:0] j_target,
  input  logic        jr_valid,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] fetch_cnt,
  output logic        halted,
  output logic [31:0] fault_pc
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  // The window bounds are widened to 33 bits so that RESET_PC+IM_BYTES
  // cannot wrap and the unsigned compare stays exact.
  localparam logic [32:0] WIN_LO = {1'b0, RESET_PC};
  localparam logic [32:0] WIN_HI = {1'b0, RESET_PC} + {1'b0, IM_BYTES};

  state_t      state;
  state_t      state_next;
  logic [31:0] cand;
  logic        cand_legal;
  logic        advance;
  logic        fault;

  // The sequential successor is needed both as a port and as the default candidate.
  assign pc_plus4 = pc + 32'd4;

  // The next-PC candidate, in fixed priority: JR, then J/JAL, then a taken branch, then PC+4.
  always_comb begin
    cand = pc_plus4;
    if (jr_valid) begin
      cand = jr_target;
    end else if (j_valid) begin
      cand = j_target;
    end else if (br_valid && br_taken) begin
      cand = br_target;
    end
  end

  // A candidate is legal if it is word aligned and inside the instruction-memory window.
  always_comb begin
    cand_legal = (cand[1:0] == 2'b00) &&
                 ({1'b0, cand} >= WIN_LO) &&
                 ({1'b0, cand} <  WIN_HI);
  end

  // The next state, plus the strobes that either advance the PC or record a fault.
  always_comb begin
    state_next = state;
    advance    = 1'b0;
    fault      = 1'b0;
    case (state)
      RUN: begin
        if (!stall) begin
          if (cand_legal) begin
            advance = 1'b1;
          end else begin
            fault      = 1'b1;
            state_next = HALT;
          end
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // The state register. Reset forces RUN immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // The PC and the fetch counter move together and only on a legal, unstalled advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      fetch_cnt <= 32'd0;
    end else if (advance) begin
      pc        <= cand;
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  // Capture the rejected address once, on entry to HALT. It then stays frozen until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_pc <= 32'd0;
    end else if (fault) begin
      fault_pc <= cand;
    end
  end

  assign halted = (state == HALT);

endmodule

// File: tb/tb_npc_sequencer.sv
// Testbench for npc_sequencer. Expected PCs are pushed to exp_q when a
// stimulus is applied, then popped and compared after the clock edge.
module tb_npc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_target;
  logic        j_valid;
  logic [31:0] j_target;
  logic        jr_valid;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] fetch_cnt;
  logic        halted;
  logic [31:0] fault_pc;

  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  int          n_checks;
  int          n_fail;

  npc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .br_valid  (br_valid),
    .br_taken  (br_taken),
    .br_target (br_target),
    .j_valid   (j_valid),
    .j_target  (j_target),
    .jr_valid  (jr_valid),
    .jr_target (jr_target),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .fetch_cnt (fetch_cnt),
    .halted    (halted),
    .fault_pc  (fault_pc)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns after it. Stimulus and sampling happen there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; br_valid = 0; br_taken = 0; br_target = 0;
    j_valid = 0; j_target = 0; jr_valid = 0; jr_target = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    repeat (3) tick();
    reset = 0;
    exp_q.delete();
  endtask

  // Pop one expected PC and compare it against the DUT.
  task automatic pop_pc(input string name);
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: expected queue empty, pc=%h", name, pc);
    end else begin
      exp_v = exp_q.pop_front();
      n_checks++;
      if (pc !== exp_v) begin
        n_fail++;
        $display("FAIL %s: pc=%h expected %h", name, pc, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    repeat (3) tick();
    n_checks++;
    if (pc !== 32'h3000 || fetch_cnt !== 0 || halted !== 0 || fault_pc !== 0) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h cnt=%h halted=%b fault=%h required 3000/0/0/0",
               pc, fetch_cnt, halted, fault_pc);
    end
    n_checks++;
    if (pc_plus4 !== 32'h3004) begin
      n_fail++;
      $display("FAIL reset_pc_plus4: %h required 3004", pc_plus4);
    end
    reset = 0;
    exp_q.delete();
    for (int i = 1; i <= 4; i++) exp_q.push_back(32'h3000 + 32'(4 * i));
    for (int i = 0; i < 4; i++) begin
      tick();
      pop_pc("sequential");
    end
    n_checks++;
    if (fetch_cnt !== 32'd4) begin
      n_fail++;
      $display("FAIL seq_cnt: fetch_cnt=%0d required 4", fetch_cnt);
    end
    // Assert reset between edges. The registers must clear without waiting for a clock.
    @(posedge clk);
    #3;
    reset = 1;
    #1;
    n_checks++;
    if (pc !== 32'h3000 || fetch_cnt !== 0) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h cnt=%h required 3000/0", pc, fetch_cnt);
    end
    repeat (2) tick();
    reset = 0;
  endtask

  task automatic test_branch(input logic taken, input logic [31:0] next_pc);
    do_reset();
    repeat (2) tick();
    n_checks++;
    if (pc !== 32'h3008) begin
      n_fail++;
      $display("FAIL branch_setup: pc=%h required 3008", pc);
    end
    br_valid = 1; br_taken = taken; br_target = 32'h3020;
    exp_q.push_back(next_pc);
    tick();
    pop_pc(taken ? "branch_taken" : "branch_not_taken");
    clear_inputs();
    exp_q.push_back(next_pc + 32'd4);
    tick();
    pop_pc("branch_after");
  endtask

  task automatic test_priority();
    do_reset();
    jr_valid = 1; jr_target = 32'h3100;
    j_valid = 1; j_target = 32'h3200;
    br_valid = 1; br_taken = 1; br_target = 32'h3300;
    exp_q.push_back(32'h3100);
    tick();
    pop_pc("prio_jr");
    jr_valid = 0;
    exp_q.push_back(32'h3200);
    tick();
    pop_pc("prio_j");
    j_valid = 0;
    exp_q.push_back(32'h3300);
    tick();
    pop_pc("prio_br");
    clear_inputs();
  endtask

  task automatic test_stall();
    logic [31:0] pc0, cnt0;
    do_reset();
    tick();
    pc0 = pc; cnt0 = fetch_cnt;
    stall = 1; j_valid = 1; j_target = 32'h3040;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h3004);
      tick();
      pop_pc("stall_hold");
    end
    n_checks++;
    if (fetch_cnt !== cnt0 || pc !== pc0) begin
      n_fail++;
      $display("FAIL stall_cnt: cnt=%0d required %0d", fetch_cnt, cnt0);
    end
    stall = 0;
    exp_q.push_back(32'h3040);
    tick();
    pop_pc("stall_release");
    n_checks++;
    if (fetch_cnt !== cnt0 + 1) begin
      n_fail++;
      $display("FAIL stall_release_cnt: cnt=%0d required %0d", fetch_cnt, cnt0 + 1);
    end
    clear_inputs();
  endtask

  task automatic test_fault_jr();
    logic [31:0] cnt0;
    do_reset();
    tick();
    cnt0 = fetch_cnt;
    jr_valid = 1; jr_target = 32'h3002;
    exp_q.push_back(32'h3004);
    tick();
    pop_pc("fault_jr_pc");
    n_checks++;
    if (halted !== 1 || fault_pc !== 32'h3002 || fetch_cnt !== cnt0) begin
      n_fail++;
      $display("FAIL fault_jr: halted=%b fault=%h cnt=%0d required 1/3002/%0d",
               halted, fault_pc, fetch_cnt, cnt0);
    end
    // Drive random inputs while halted. Every output must stay frozen.
    for (int i = 0; i < 6; i++) begin
      stall = 1'($urandom_range(0, 1));
      jr_valid = 1'($urandom_range(0, 1));
      jr_target = 32'h3000 + 32'($urandom_range(0, 255) * 4);
      j_valid = 1'($urandom_range(0, 1));
      j_target = 32'h3010;
      br_valid = 1; br_taken = 1; br_target = 32'h3020;
      tick();
      n_checks++;
      if (halted !== 1 || pc !== 32'h3004 || fault_pc !== 32'h3002 || fetch_cnt !== cnt0) begin
        n_fail++;
        $display("FAIL halt_frozen: halted=%b pc=%h fault=%h cnt=%0d", halted, pc, fault_pc, fetch_cnt);
      end
    end
    clear_inputs();
    reset = 1;
    #1;
    n_checks++;
    if (halted !== 0 || fault_pc !== 0 || pc !== 32'h3000) begin
      n_fail++;
      $display("FAIL halt_reset: halted=%b fault=%h pc=%h required 0/0/3000", halted, fault_pc, pc);
    end
    tick();
    reset = 0;
  endtask

  task automatic test_fault_j();
    do_reset();
    j_valid = 1; j_target = 32'h6000;
    exp_q.push_back(32'h3000);
    tick();
    pop_pc("fault_j_pc");
    n_checks++;
    if (halted !== 1 || fault_pc !== 32'h6000) begin
      n_fail++;
      $display("FAIL fault_j: halted=%b fault=%h required 1/6000", halted, fault_pc);
    end
    clear_inputs();
  endtask

  task automatic test_fault_last_word();
    do_reset();
    jr_valid = 1; jr_target = 32'h5FFC;
    exp_q.push_back(32'h5FFC);
    tick();
    pop_pc("last_word_reach");
    n_checks++;
    if (halted !== 0) begin
      n_fail++;
      $display("FAIL last_word_legal: halted=%b required 0", halted);
    end
    clear_inputs();
    exp_q.push_back(32'h5FFC);
    tick();
    pop_pc("last_word_hold");
    n_checks++;
    if (halted !== 1 || fault_pc !== 32'h6000 || fetch_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL last_word_fault: halted=%b fault=%h cnt=%0d required 1/6000/1",
               halted, fault_pc, fetch_cnt);
    end
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    tick();
    @(negedge clk);
    force dut.fetch_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt;
    exp_q.push_back(32'h3008);
    tick();
    pop_pc("wrap_pc");
    n_checks++;
    if (fetch_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL cnt_wrap: cnt=%h required 0", fetch_cnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1;
    clear_inputs();
    test_reset();
    test_branch(1'b1, 32'h3020);
    test_branch(1'b0, 32'h300C);
    test_priority();
    test_stall();
    test_fault_jr();
    test_fault_j();
    test_fault_last_word();
    test_cnt_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
